uart_tx: RTL and testbench

//  OCP slave UART transmitter: drop-in successor to micro_uart on the peripheral bus.

---
 rtl/uart_tx_pkg.sv | 51 +++++
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_tx_sync_fifo.sv | 43 ++++
 rtl/uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: bus widths, OCP codes, register map,
// STATUS layout and serializer state encodings.
package uart_tx_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = 4;

  typedef enum logic [2:0] {
    OCP_IDLE  = 3'd0,
    OCP_WRITE = 3'd1,
    OCP_READ  = 3'd2
  } ocp_cmd_e;

  typedef enum logic [1:0] {
    RESP_NULL = 2'd0,
    RESP_DVA  = 2'd1,
    RESP_ERR  = 2'd3
  } ocp_resp_e;

  // Register select is MAddr[3:2]
  localparam logic [1:0] REG_CHAR   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // First field is the MSB, so busy lands on bit 0
  typedef struct packed {
    logic ovf;
    logic fifo_empty;
    logic fifo_full;
    logic busy;
  } status_t;

  function automatic logic [15:0] merge_div(input logic [15:0] old_div,
                                            input logic [15:0] wdata,
                                            input logic [1:0]  ben);
    merge_div[15:8] = ben[1] ? wdata[15:8] : old_div[15:8];
    merge_div[7:0]  = ben[0] ? wdata[7:0]  : old_div[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// OCP request/response bundle between a bus master and the UART transmitter.
interface uart_tx_if;
  import uart_tx_pkg::*;

  logic [ADDR_WIDTH-1:0] i_MAddr;
  logic [2:0]            i_MCmd;
  logic [DATA_WIDTH-1:0] i_MData;
  logic [BEN_WIDTH-1:0]  i_MByteEn;
  logic                  o_SCmdAccept;
  logic [DATA_WIDTH-1:0] o_SData;
  logic [1:0]            o_SResp;

  modport slave (
    input  i_MAddr, i_MCmd, i_MData, i_MByteEn,
    output o_SCmdAccept, o_SData, o_SResp
  );

  modport master (
    output i_MAddr, i_MCmd, i_MData, i_MByteEn,
    input  o_SCmdAccept, o_SData, o_SResp
  );

endinterface

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with registered read data; pointers carry an extra wrap bit.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  // A push into a full FIFO is only issued alongside a pop; the read of the
  // shared slot sees the old entry because both updates are non-blocking.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    if (i_pop)  r_rdata <= r_mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_rdata = r_rdata;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx.sv
// OCP slave UART transmitter: register decode, TX FIFO, baud divider and 8N1 shifter.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_AW     = 3,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic      clk,
  input  logic      nrst,
  uart_tx_if.slave  bus,
  output logic      o_tx
);

  logic [1:0]            r_sresp;
  logic [DATA_WIDTH-1:0] r_sdata;
  logic                  r_ovf;
  logic [15:0]           r_div;
  logic [1:0]            r_state;
  logic [15:0]           r_cnt;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic                  r_tx;

  logic [1:0]            w_reg_sel;
  logic [1:0]            w_resp_next;
  logic [DATA_WIDTH-1:0] w_rdata_next;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ovf_set;
  logic                  w_ovf_clr;
  logic                  w_div_wr;
  logic                  w_bit_end;
  logic [7:0]            w_fifo_rdata;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  status_t               w_status;
  logic                  w_unused_bits;

  assign w_reg_sel          = bus.i_MAddr[3:2];
  assign bus.o_SCmdAccept   = (bus.i_MCmd != OCP_IDLE);
  assign bus.o_SResp        = r_sresp;
  assign bus.o_SData        = r_sdata;
  assign o_tx               = r_tx;
  assign w_unused_bits      = ^{bus.i_MAddr[ADDR_WIDTH-1:4], bus.i_MAddr[1:0],
                                bus.i_MData[DATA_WIDTH-1:16], bus.i_MByteEn[BEN_WIDTH-1:2]};

  assign w_status = '{ovf: r_ovf, fifo_empty: w_fifo_empty, fifo_full: w_fifo_full,
                      busy: (r_state != ST_IDLE)};

  // Pops happen when idle, or in the final STOP cycle for gap-free back-to-back frames
  assign w_bit_end = (r_cnt == 16'd0);
  assign w_pop     = !w_fifo_empty &&
                     ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

  always_comb begin
    w_resp_next  = RESP_NULL;
    w_rdata_next = '0;
    w_push       = 1'b0;
    w_ovf_set    = 1'b0;
    w_ovf_clr    = 1'b0;
    w_div_wr     = 1'b0;
    if (bus.i_MCmd == OCP_WRITE) begin
      case (w_reg_sel)
        REG_CHAR: begin
          w_resp_next = RESP_DVA;
          if (bus.i_MByteEn[0]) begin
            if (!w_fifo_full || w_pop) begin
              w_push = 1'b1;
            end else begin
              w_ovf_set   = 1'b1;
              w_resp_next = RESP_ERR;
            end
          end
        end
        REG_STATUS: w_resp_next = RESP_DVA;
        REG_BAUD: begin
          w_div_wr    = 1'b1;
          w_resp_next = RESP_DVA;
        end
        default: w_resp_next = RESP_ERR;
      endcase
    end else if (bus.i_MCmd == OCP_READ) begin
      case (w_reg_sel)
        REG_CHAR:   w_resp_next = RESP_DVA;
        REG_STATUS: begin
          w_resp_next  = RESP_DVA;
          w_rdata_next = DATA_WIDTH'(w_status);
          w_ovf_clr    = 1'b1;
        end
        REG_BAUD: begin
          w_resp_next  = RESP_DVA;
          w_rdata_next = DATA_WIDTH'(r_div);
        end
        default: w_resp_next = RESP_ERR;
      endcase
    end else if (bus.i_MCmd != OCP_IDLE) begin
      w_resp_next = RESP_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_sresp <= RESP_NULL;
      r_sdata <= '0;
      r_ovf   <= 1'b0;
      r_div   <= DEFAULT_DIV;
    end else begin
      r_sresp <= w_resp_next;
      r_sdata <= w_rdata_next;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_div_wr) r_div <= merge_div(r_div, bus.i_MData[15:0], bus.i_MByteEn[1:0]);
    end
  end

  sync_fifo #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_push),
    .i_wdata (bus.i_MData[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Each bit reloads the counter from r_div, so a divider write only affects the next bit
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (!w_fifo_empty) begin
            r_state <= ST_START;
            r_cnt   <= r_div;
            r_tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_cnt     <= r_div;
            r_shift   <= w_fifo_rdata;
            r_tx      <= w_fifo_rdata[0];
            r_bit_idx <= '0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt     <= r_div;
            r_bit_idx <= r_bit_idx + 3'd1;
            r_shift   <= r_shift >> 1;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (!w_fifo_empty) begin
              r_state <= ST_START;
              r_cnt   <= r_div;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: OCP one-cycle command pulses, o_tx checked every cycle of a frame.
module tb_uart_tx;
  import uart_tx_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic o_tx;
  int   n_checks = 0;
  int   n_pass = 0;

  uart_tx_if bus();

  uart_tx #(
    .FIFO_AW     (3),
    .DEFAULT_DIV (16'd433)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus),
    .o_tx (o_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drives one command cycle starting just after an edge; returns just after the next edge
  task automatic ocp(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] ben, output logic [1:0] resp, output logic [31:0] rdata);
    bus.i_MCmd    = cmd;
    bus.i_MAddr   = addr;
    bus.i_MData   = data;
    bus.i_MByteEn = ben;
    #1;
    chk("accept", 32'(bus.o_SCmdAccept), 32'(cmd != 3'd0));
    @(posedge clk);
    #1;
    bus.i_MCmd    = 3'd0;
    bus.i_MAddr   = '0;
    bus.i_MData   = '0;
    bus.i_MByteEn = '0;
    resp  = bus.o_SResp;
    rdata = bus.o_SData;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] ben,
                    input logic [1:0] exp_resp, input string tag);
    logic [1:0]  r;
    logic [31:0] d;
    ocp(3'd1, addr, data, ben, r, d);
    chk({tag, ".resp"}, 32'(r), 32'(exp_resp));
  endtask

  task automatic rd(input logic [31:0] addr, input logic [1:0] exp_resp,
                    input logic [31:0] exp_data, input string tag);
    logic [1:0]  r;
    logic [31:0] d;
    ocp(3'd2, addr, 32'd0, 4'h0, r, d);
    chk({tag, ".resp"}, 32'(r), 32'(exp_resp));
    chk({tag, ".data"}, d, exp_data);
  endtask

  // pat[0] is the first bit on the line; each bit is checked on all div+1 of its cycles
  task automatic check_frame(input logic [9:0] pat, input int div, input string tag);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c <= div; c++) begin
        @(posedge clk);
        #1;
        chk($sformatf("%s.bit%0d.c%0d", tag, b, c), 32'(o_tx), 32'(pat[b]));
      end
    end
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic [7:0]  msg [6];
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};

    bus.i_MCmd    = 3'd0;
    bus.i_MAddr   = '0;
    bus.i_MData   = '0;
    bus.i_MByteEn = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.tx", 32'(o_tx), 32'd1);
    chk("rst.sresp", 32'(bus.o_SResp), 32'd0);
    chk("rst.sdata", bus.o_SData, 32'd0);
    nrst = 1'b1;

    // Register map: STATUS idle, BAUDDIV default, lane-0-only write, unmapped, bad command
    rd(32'h004, 2'd1, 32'h4, "status_idle");
    rd(32'h008, 2'd1, 32'd433, "baud_rst");
    wr(32'h008, 32'h0000_0102, 4'h1, 2'd1, "baud_lane0");
    rd(32'h008, 2'd1, 32'h0102, "baud_lane0_rb");
    @(posedge clk);
    #1;
    chk("resp_hold.sresp", 32'(bus.o_SResp), 32'd0);
    chk("resp_hold.sdata", bus.o_SData, 32'd0);
    rd(32'h00C, 2'd3, 32'd0, "unmapped");
    ocp(3'd5, 32'h000, 32'h77, 4'h1, r, d);
    chk("badcmd.resp", 32'(r), 32'd3);
    rd(32'h004, 2'd1, 32'h4, "badcmd_nopush");
    rd(32'h000, 2'd1, 32'd0, "charreg_rd");

    // Lane 0 disabled on CHARREG: DVA and nothing queued
    wr(32'h000, 32'h41, 4'h2, 2'd1, "char_noben");
    rd(32'h004, 2'd1, 32'h4, "char_noben_status");

    // Single frame, DIV=3, 'H'
    wr(32'h008, 32'd3, 4'h3, 2'd1, "div3");
    wr(32'h000, 32'h48, 4'h1, 2'd1, "wr_H");
    check_frame(10'b1_01001000_0, 3, "frame_H");
    @(posedge clk);
    #1;
    chk("idle_after_H", 32'(o_tx), 32'd1);
    rd(32'h004, 2'd1, 32'h4, "status_after_H");

    // "Hello\n" back-to-back, no idle gaps
    fork
      begin
        for (int i = 0; i < 6; i++) wr(32'h000, 32'(msg[i]), 4'h1, 2'd1, $sformatf("wr_hello%0d", i));
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 6; i++) check_frame({1'b1, msg[i], 1'b0}, 3, $sformatf("hello%0d", i));
      end
    join
    @(posedge clk);
    #1;
    chk("idle_after_hello", 32'(o_tx), 32'd1);
    rd(32'h004, 2'd1, 32'h4, "status_after_hello");

    // DIV=0: one cycle per bit, 0xA5
    wr(32'h008, 32'd0, 4'h3, 2'd1, "div0");
    wr(32'h000, 32'hA5, 4'h1, 2'd1, "wr_A5");
    check_frame(10'b1_10100101_0, 0, "frame_A5");
    @(posedge clk);
    #1;
    chk("idle_after_A5", 32'(o_tx), 32'd1);

    // DIV=433: one byte sending plus eight queued fills the FIFO; the next write overflows
    wr(32'h008, 32'd433, 4'h3, 2'd1, "div433");
    wr(32'h000, 32'h55, 4'h1, 2'd1, "ovf_first");
    for (int i = 1; i <= 8; i++) wr(32'h000, 32'(i), 4'h1, 2'd1, $sformatf("ovf_fill%0d", i));
    wr(32'h000, 32'h99, 4'h1, 2'd3, "ovf_drop");
    rd(32'h004, 2'd1, 32'hB, "status_ovf");
    rd(32'h004, 2'd1, 32'h3, "status_ovf_cleared");

    // Reset during DATA bit 1 of 0x55 (a low bit)
    repeat (1000) @(posedge clk);
    #1;
    chk("pre_rst_tx", 32'(o_tx), 32'd0);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_tx", 32'(o_tx), 32'd1);
    nrst = 1'b1;
    rd(32'h004, 2'd1, 32'h4, "status_after_rst");
    rd(32'h008, 2'd1, 32'd433, "baud_after_rst");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("no_stale%0d", i), 32'(o_tx), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
